// File: rtl/sp_ram_hs.sv
// Single-port SRAM wrapper with req/gnt/rvalid handshake, byte enables,
// optional output register and a post-reset zero-fill sequencer.
module sp_ram_hs #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 1024,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam int CW  = $clog2(NUM_WORDS);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt, busy, clr_we;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   mem_idx;
  logic            in_range;
  logic            wr_en;
  logic            unused_addr;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  assign idx         = addr_i[ADDR_WIDTH-1:OFF];
  assign mem_idx     = CW'(idx);
  assign in_range    = 64'(idx) < 64'(NUM_WORDS);
  assign unused_addr = ^addr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    busy    = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == CW'(NUM_WORDS - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        gnt = req_i;
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // Grants are held off while reset is asserted, even with CLEAR disabled.
  assign gnt_o  = gnt & ~rst;
  assign busy_o = busy;
  assign wr_en  = gnt_o & we_i & in_range;

  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BW; b++) begin
        if (be_i[b]) mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  logic                  rv0, er0;
  logic [DATA_WIDTH-1:0] rd0;

  // Read-first: the array read sees contents before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv0 <= 1'b0;
      rd0 <= '0;
      er0 <= 1'b0;
    end else begin
      rv0 <= gnt_o;
      if (gnt_o) begin
        rd0 <= in_range ? mem[mem_idx] : '0;
        er0 <= ~in_range;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  rv1, er1;
      logic [DATA_WIDTH-1:0] rd1;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rv1 <= 1'b0;
          rd1 <= '0;
          er1 <= 1'b0;
        end else begin
          rv1 <= rv0;
          if (rv0) begin
            rd1 <= rd0;
            er1 <= er0;
          end
        end
      end

      assign rvalid_o = rv1;
      assign rdata_o  = rd1;
      assign err_o    = er1;
    end else begin : g_noreg
      assign rvalid_o = rv0;
      assign rdata_o  = rd0;
      assign err_o    = er0;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_hs.sv
// Bench for sp_ram_hs: OUT_REG=0 and OUT_REG=1 instances on shared stimulus,
// checked against a word-array reference model with response pipelines.
module tb_sp_ram_hs;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wdata;

  logic          gnt0, rv0, er0, bz0;
  logic [DW-1:0] rd0;
  logic          gnt1, rv1, er1, bz1;
  logic [DW-1:0] rd1;

  always #5 clk = ~clk;

  sp_ram_hs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
    .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt0),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rv0), .rdata_o(rd0), .err_o(er0), .busy_o(bz0)
  );

  sp_ram_hs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
    .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt1),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1), .busy_o(bz1)
  );

  // Reference model: word array, clear countdown, 1- and 2-cycle response views
  logic [DW-1:0] mmem [NW];
  int            clear_left;
  logic          p_v, p_e, q_v, q_e;
  logic [DW-1:0] p_d, q_d;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    chk("rvalid0", 32'(rv0), 32'(p_v));
    chk("rdata0", rd0, p_d);
    chk("err0", 32'(er0), 32'(p_e));
    chk("rvalid1", 32'(rv1), 32'(q_v));
    chk("rdata1", rd1, q_d);
    chk("err1", 32'(er1), 32'(q_e));
  endtask

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [3:0] b, input logic [DW-1:0] d);
    logic g;
    int   i;
    check_outputs();
    req = r; we = w; addr = a; be = b; wdata = d;
    #1;
    g = (clear_left == 0) && r;
    chk("gnt0", 32'(gnt0), 32'(g));
    chk("gnt1", 32'(gnt1), 32'(g));
    chk("busy0", 32'(bz0), 32'(clear_left > 0));
    chk("busy1", 32'(bz1), 32'(clear_left > 0));
    i = int'(a) / 4;
    q_v = p_v;
    if (p_v) begin
      q_d = p_d;
      q_e = p_e;
    end
    p_v = g;
    if (g) begin
      if (i >= NW) begin
        p_d = '0;
        p_e = 1'b1;
      end else begin
        p_d = mmem[i];
        p_e = 1'b0;
        if (w) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) mmem[i][8*k +: 8] = d[8*k +: 8];
        end
      end
    end
    if (clear_left > 0) clear_left--;
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, 4'($urandom), $urandom);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] b,
                    input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, b, d);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom), AW'($urandom), 4'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b1;
    #1;
    p_v = 1'b0; p_d = '0; p_e = 1'b0;
    q_v = 1'b0; q_d = '0; q_e = 1'b0;
    clear_left = NW;
    for (int k = 0; k < NW; k++) mmem[k] = '0;
    check_outputs();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_busy0", 32'(bz0), 32'd1);
    chk("rst_busy1", 32'(bz1), 32'd1);
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0;
    addr = '0; be = '0; wdata = '0;
    @(negedge clk);
    do_reset();
    repeat (NW + 1) rd(AW'($urandom));

    for (int k = 0; k < NW; k++) wr(AW'(4 * k), 4'hF, 32'hA5A5A5A5);
    do_reset();
    repeat (NW) rd(AW'($urandom));
    for (int k = 0; k < 16; k++) rd(AW'(4 * k + int'($urandom_range(0, 3))));
    repeat (3) idle();

    wr(6'h08, 4'hF, 32'h11223344);
    wr(6'h08, 4'h5, 32'hAABBCCDD);
    rd(6'h08);
    repeat (3) idle();

    for (int k = 0; k < 8; k++) rd(AW'(4 * k));
    repeat (3) idle();

    wr(AW'(4 * 12), 4'hF, 32'hDEADBEEF);
    rd(AW'(4 * 12));
    rd(AW'(4 * 11));
    repeat (3) idle();

    wr(AW'(4 * 3), 4'hF, 32'h00000001);
    rd(AW'(4 * 3));
    repeat (3) idle();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 2) idle();
      else step(1'b1, 1'($urandom), AW'($urandom), 4'($urandom), $urandom);
    end
    repeat (3) idle();

    rd(6'h00);
    rd(6'h04);
    do_reset();
    repeat (NW) rd(AW'($urandom));
    for (int k = 0; k < 4; k++) rd(AW'(4 * k));
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_ram_hs.md
# sp_ram_hs

Parametrised single-port SRAM macro wrapper with a request/grant/rvalid handshake, byte-enable writes, an optional output register stage, and a post-reset memory-clear sequencer. It sits between a core/debug/DMA bus port and on-chip instruction or data memory. It replaces bare fixed-latency RAM instances wherever a master needs an explicit response-valid strobe, range checking or zero-initialised memory.

## Interface
- ADDR_WIDTH, 12: byte-address width.
- DATA_WIDTH, 32: word width in bits; multiple of 8, ≥ 8, power of two.
- NUM_WORDS, 1024: depth in words (not bytes); ≥ 2, need not be a power of two.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- CLEAR_ON_RESET, 1: 1 zeroes all words after reset before the first grant.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle (combinational from req_i and state).
- addr_i  in  ADDR_WIDTH  byte address; word index = addr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low bits ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables for writes; ignored for reads.
- wdata_i  in  DATA_WIDTH  write data; byte b = wdata_i[8b+7:8b].
- rvalid_o  out  1  response strobe; exactly one per granted request (read or write).
- rdata_o  out  DATA_WIDTH  read data; valid only with rvalid_o.
- err_o  out  1  out-of-range flag; valid only with rvalid_o.
- busy_o  out  1  clear sequence in progress.

## Operation
- States: CLEAR and READY. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- CLEAR: the counter runs 0..NUM_WORDS-1 and writes all-zero words, one per cycle. busy_o=1 and gnt_o=0 throughout. After the write of NUM_WORDS-1 the block moves to READY. CLEAR takes exactly NUM_WORDS cycles.
- READY: gnt_o = req_i. There is no response backpressure, so the block sustains one request per cycle.
- Range check: a word index ≥ NUM_WORDS is out of range. The request is still granted, but a write is suppressed and a read returns all zeros. err_o=1 in that request's response beat. In-range requests respond with err_o=0.
- Write: only bytes with be_i[b]=1 are updated. be_i=0 is a legal no-op that still produces a response. The write response has rdata_o = previous word contents (read-first).
- Read-during-write: a read granted the cycle after a write to the same word returns the new data. A write's own response returns the old data.
- rdata_o and err_o hold their last values while rvalid_o=0.
- Reset mid-operation: rst asserted at any time flushes all in-flight responses with no rvalid_o and restarts CLEAR from word 0. Memory contents are undefined until that clear completes (or are retained if CLEAR_ON_RESET=0).
- Clear counter width: clog2(NUM_WORDS). The counter does not wrap; its terminal compare is against NUM_WORDS-1.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, busy_o=CLEAR_ON_RESET.
- A grant in cycle N gives rvalid_o in cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Responses are in order.
- With back-to-back grants, rvalid_o stays high continuously.
- busy_o falls, and gnt_o may first assert, in the cycle after the last clear write.
- Memory array: one write port and one synchronous read port with the same address, mapping to a single-port macro.

## Test plan
- Reset clear: NUM_WORDS=16, CLEAR_ON_RESET=1, memory preloaded with 0xA5A5A5A5, req_i held high. Required: busy_o=1 and gnt_o=0 for exactly 16 cycles; then every read of words 0..15 returns 0x00000000.
- Byte-enable write: write 0x11223344 to addr 0x8 with be=0xF, then 0xAABBCCDD with be=0x5, then read addr 0x8. Required: 0x11BB33DD; the second write's response returns 0x11223344.
- Latency/throughput: 8 back-to-back reads, run with OUT_REG=0 and with OUT_REG=1. Required: rvalid_o first rises 1 or 2 cycles after the first grant respectively, stays high for 8 consecutive cycles, and data comes back in order.
- Out of range: NUM_WORDS=12, write 0xDEADBEEF to word 12, then read word 12 and word 11. Required: err_o=1 on both word-12 responses and the read returns 0; the word-11 response has err_o=0 and its contents are unchanged.
- Reset mid-burst: assert rst while two reads are in flight. Required: no rvalid_o is produced for either read, outputs return to reset values immediately, and a full CLEAR re-runs from word 0.
- Read after write: write 0x00000001 to word 3, and read word 3 the next cycle. Required: the read returns 0x00000001.
